// File: rtl/noc_route_pkg.sv
// noc_route_pkg: shared mesh-routing definitions (port encodings, service order,
// FSM states and the XY dimension-order routing function).
package noc_route_pkg;

    localparam int NPORTS    = 5;
    localparam int IDX_N     = 0;
    localparam int IDX_E     = 1;
    localparam int IDX_S     = 2;
    localparam int IDX_W     = 3;
    localparam int IDX_LOCAL = 4;

    localparam logic [NPORTS-1:0] PORT_NONE  = 5'b00000;
    localparam logic [NPORTS-1:0] PORT_N     = 5'b00001;
    localparam logic [NPORTS-1:0] PORT_E     = 5'b00010;
    localparam logic [NPORTS-1:0] PORT_S     = 5'b00100;
    localparam logic [NPORTS-1:0] PORT_W     = 5'b01000;
    localparam logic [NPORTS-1:0] PORT_LOCAL = 5'b10000;

    // Pending subsets are served local-eject first, then N, E, S, W.
    localparam int PRIO_ORDER [NPORTS] = '{IDX_LOCAL, IDX_N, IDX_E, IDX_S, IDX_W};

    typedef enum logic {
        ST_IDLE,
        ST_EMIT
    } state_t;

    function automatic logic [NPORTS-1:0] xy_port(input int dx, input int dy,
                                                  input int mx, input int my);
        if (dx > mx)
            return PORT_E;
        else if (dx < mx)
            return PORT_W;
        else if (dy > my)
            return PORT_S;
        else if (dy < my)
            return PORT_N;
        else
            return PORT_LOCAL;
    endfunction

    function automatic logic [NPORTS-1:0] prio_pick(input logic [NPORTS-1:0] pend);
        logic [NPORTS-1:0] r;
        r = PORT_NONE;
        // Walk from lowest to highest priority so the highest set bit wins.
        for (int k = NPORTS - 1; k >= 0; k--) begin
            if (pend[PRIO_ORDER[k]]) begin
                r = PORT_NONE;
                r[PRIO_ORDER[k]] = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mc_partition.sv
// mc_partition: splits a multicast destination bitmap into per-output-port
// subsets using XY routing relative to this router, plus a non-empty vector.
module mc_partition
    import noc_route_pkg::*;
#(
    parameter int ARRAY_X = 5,
    parameter int ARRAY_Y = 4,
    parameter int MY_XPOS = 0,
    parameter int MY_YPOS = 0,
    localparam int NODES  = ARRAY_X * ARRAY_Y
) (
    input  logic [NODES-1:0]  maddr,
    output logic [NODES-1:0]  sub_n,
    output logic [NODES-1:0]  sub_e,
    output logic [NODES-1:0]  sub_s,
    output logic [NODES-1:0]  sub_w,
    output logic [NODES-1:0]  sub_local,
    output logic [NPORTS-1:0] nonempty
);

    logic [NPORTS-1:0] node_port;

    always_comb begin
        sub_n     = '0;
        sub_e     = '0;
        sub_s     = '0;
        sub_w     = '0;
        sub_local = '0;
        node_port = PORT_NONE;
        for (int i = 0; i < NODES; i++) begin
            node_port    = xy_port(i / ARRAY_Y, i % ARRAY_Y, MY_XPOS, MY_YPOS);
            sub_n[i]     = maddr[i] & node_port[IDX_N];
            sub_e[i]     = maddr[i] & node_port[IDX_E];
            sub_s[i]     = maddr[i] & node_port[IDX_S];
            sub_w[i]     = maddr[i] & node_port[IDX_W];
            sub_local[i] = maddr[i] & node_port[IDX_LOCAL];
        end
    end

    assign nonempty = {|sub_local, |sub_w, |sub_s, |sub_e, |sub_n};

endmodule

// File: rtl/mc_route_split.sv
// mc_route_split: accepts unicast/multicast headers and emits one port request per
// non-empty XY subset. Multicast forking is built only when MCAST_EN is defined.
module mc_route_split
    import noc_route_pkg::*;
#(
    parameter int ARRAY_X = 5,
    parameter int ARRAY_Y = 4,
    parameter int MY_XPOS = 0,
    parameter int MY_YPOS = 0,
    localparam int NODES  = ARRAY_X * ARRAY_Y,
    localparam int UW     = $clog2(NODES),
    localparam int MY_POS = MY_XPOS * ARRAY_Y + MY_YPOS
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_um_type,
    input  logic [UW-1:0]     in_uaddr,
    input  logic [NODES-1:0]  in_maddr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NPORTS-1:0] out_port,
    output logic [NODES-1:0]  out_maddr,
    output logic              out_absorb,
    output logic              out_last,
    output logic              err_bad_addr
);

    state_t            state, state_nxt;
    logic              accept, handshake, drop, uaddr_bad, rest_empty, err_q;
    logic [NPORTS-1:0] uport, cur_port;
    logic [NODES-1:0]  cur_maddr;

    assign accept    = in_valid && (state == ST_IDLE);
    assign handshake = (state == ST_EMIT) && out_ready;
    assign uaddr_bad = int'(in_uaddr) >= NODES;

    always_comb begin
        uport = PORT_NONE;
        for (int i = 0; i < NODES; i++) begin
            if (int'(in_uaddr) == i)
                uport = xy_port(i / ARRAY_Y, i % ARRAY_Y, MY_XPOS, MY_YPOS);
        end
    end

`ifdef MCAST_EN
    localparam logic [NODES-1:0] LOCAL_BIT = {{(NODES-1){1'b0}}, 1'b1} << MY_POS;

    logic [NODES-1:0]  part_n, part_e, part_s, part_w, part_local;
    logic [NPORTS-1:0] part_ne, pending, sel;
    logic [NODES-1:0]  sub_q [NPORTS];

    mc_partition #(
        .ARRAY_X (ARRAY_X),
        .ARRAY_Y (ARRAY_Y),
        .MY_XPOS (MY_XPOS),
        .MY_YPOS (MY_YPOS)
    ) u_partition (
        .maddr     (in_maddr),
        .sub_n     (part_n),
        .sub_e     (part_e),
        .sub_s     (part_s),
        .sub_w     (part_w),
        .sub_local (part_local),
        .nonempty  (part_ne)
    );

    assign drop       = in_um_type ? (in_maddr == '0) : uaddr_bad;
    assign sel        = prio_pick(pending);
    assign cur_port   = sel;
    assign rest_empty = (pending & ~sel) == '0;

    // Subsets are captured once per header; only the pending mask shrinks as requests go.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            pending <= '0;
            for (int k = 0; k < NPORTS; k++)
                sub_q[k] <= '0;
        end else if (accept && !drop) begin
            if (in_um_type) begin
                pending          <= part_ne;
                sub_q[IDX_N]     <= part_n;
                sub_q[IDX_E]     <= part_e;
                sub_q[IDX_S]     <= part_s;
                sub_q[IDX_W]     <= part_w;
                sub_q[IDX_LOCAL] <= part_local;
            end else begin
                pending          <= uport;
                sub_q[IDX_N]     <= '0;
                sub_q[IDX_E]     <= '0;
                sub_q[IDX_S]     <= '0;
                sub_q[IDX_W]     <= '0;
                sub_q[IDX_LOCAL] <= LOCAL_BIT;
            end
        end else if (handshake) begin
            pending <= pending & ~sel;
        end
    end

    always_comb begin
        cur_maddr = '0;
        for (int k = 0; k < NPORTS; k++) begin
            if (sel[k])
                cur_maddr = sub_q[k];
        end
    end
`else
    logic [NPORTS-1:0] port_q;
    logic              unused_mcast;

    assign unused_mcast = ^{in_um_type, in_maddr};
    assign drop         = uaddr_bad;
    assign cur_port     = port_q;
    assign cur_maddr    = '0;
    assign rest_empty   = 1'b1;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_)
            port_q <= PORT_NONE;
        else if (accept && !drop)
            port_q <= uport;
    end
`endif

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state <= ST_IDLE;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            err_q <= accept && drop;
        end
    end

    // in_ready only rises once the final request has left, never in the same cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept && !drop) state_nxt = ST_EMIT;
            ST_EMIT: if (handshake && rest_empty) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready     = (state == ST_IDLE);
        out_valid    = (state == ST_EMIT);
        err_bad_addr = err_q;
        out_port     = PORT_NONE;
        out_maddr    = '0;
        out_absorb   = 1'b0;
        if (state == ST_EMIT) begin
            out_port   = cur_port;
            out_maddr  = cur_maddr;
            out_absorb = cur_port[IDX_LOCAL];
        end
`ifdef MCAST_EN
        out_last = (state == ST_EMIT) && rest_empty;
`else
        out_last = 1'b1;
`endif
    end

endmodule

// File: tb/tb_mc_route_split.sv
// tb_mc_route_split: directed scoreboard bench for mc_route_split at router (2,1)
// of a 5x4 mesh; multicast cases are exercised when MCAST_EN is defined.
module tb_mc_route_split;

    localparam int AX = 5;
    localparam int AY = 4;
    localparam int NN = AX * AY;
`ifdef MCAST_EN
    localparam bit MC = 1'b1;
`else
    localparam bit MC = 1'b0;
`endif

    typedef struct packed {
        logic [4:0]    port;
        logic [NN-1:0] maddr;
        logic          absorb;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_ = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_um_type = 1'b0;
    logic [4:0]    in_uaddr = '0;
    logic [NN-1:0] in_maddr = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [4:0]    out_port;
    logic [NN-1:0] out_maddr;
    logic          out_absorb;
    logic          out_last;
    logic          err_bad_addr;

    int    total = 0;
    int    bad = 0;
    int    vcycles = 0;
    beat_t sb [$];

    localparam logic [NN-1:0] MC_MAP = 20'h22B0A;

    mc_route_split #(.ARRAY_X(AX), .ARRAY_Y(AY), .MY_XPOS(2), .MY_YPOS(1)) dut (
        .clk          (clk),
        .rst_         (rst_),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_um_type   (in_um_type),
        .in_uaddr     (in_uaddr),
        .in_maddr     (in_maddr),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_port     (out_port),
        .out_maddr    (out_maddr),
        .out_absorb   (out_absorb),
        .out_last     (out_last),
        .err_bad_addr (err_bad_addr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic um, input logic [4:0] ua, input logic [NN-1:0] ma);
        in_valid   = 1'b1;
        in_um_type = um;
        in_uaddr   = ua;
        in_maddr   = ma;
        @(posedge clk); #1;
        in_valid   = 1'b0;
    endtask

    task automatic pushBeat(input logic [4:0] p, input logic [NN-1:0] m, input logic a, input logic l);
        beat_t b;
        b.port   = p;
        b.maddr  = m;
        b.absorb = a;
        b.last   = l;
        sb.push_back(b);
    endtask

    task automatic pushMcast();
        pushBeat(5'b10000, 20'h00200, 1'b1, 1'b0);
        pushBeat(5'b00001, 20'h00100, 1'b0, 1'b0);
        pushBeat(5'b00010, 20'h22000, 1'b0, 1'b0);
        pushBeat(5'b00100, 20'h00800, 1'b0, 1'b0);
        pushBeat(5'b01000, 20'h0000A, 1'b0, 1'b1);
    endtask

    task automatic waitIdle(input string tag);
        int n;
        n = 0;
        while ((sb.size() != 0 || !in_ready) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput({tag, "_drain"}, {31'b0, (sb.size() == 0 && in_ready)}, 32'd1);
    endtask

    // Monitor: every accepted request is popped from the scoreboard and compared.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (rst_ && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_beat: got port %b want no request", out_port);
                end else begin
                    e = sb.pop_front();
                    checkOutput("beat_port", {27'b0, out_port}, {27'b0, e.port});
                    checkOutput("beat_maddr", {12'b0, out_maddr}, {12'b0, e.maddr});
                    checkOutput("beat_absorb", {31'b0, out_absorb}, {31'b0, e.absorb});
                    checkOutput("beat_last", {31'b0, out_last}, {31'b0, e.last});
                end
            end
        end
    end

    always @(negedge clk) if (out_valid) vcycles++;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rst_out_port", {27'b0, out_port}, 32'd0);
        checkOutput("rst_out_maddr", {12'b0, out_maddr}, 32'd0);
        checkOutput("rst_out_absorb", {31'b0, out_absorb}, 32'd0);
        checkOutput("rst_out_last", {31'b0, out_last}, {31'b0, !MC});
        checkOutput("rst_err", {31'b0, err_bad_addr}, 32'd0);
        rst_ = 1'b1;
        @(posedge clk); #1;

        $display("[TB] unicast to node 17");
        pushBeat(5'b00010, '0, 1'b0, 1'b1);
        applyStimulus(1'b0, 5'd17, '0);
        checkOutput("u17_latency", {31'b0, out_valid}, 32'd1);
        checkOutput("u17_in_ready", {31'b0, in_ready}, 32'd0);
        waitIdle("u17");

        $display("[TB] unicast to out-of-range node 20");
        applyStimulus(1'b0, 5'd20, '0);
        checkOutput("bad_u_err", {31'b0, err_bad_addr}, 32'd1);
        checkOutput("bad_u_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("bad_u_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        checkOutput("bad_u_err_clr", {31'b0, err_bad_addr}, 32'd0);
        checkOutput("bad_u_valid2", {31'b0, out_valid}, 32'd0);

        $display("[TB] unicast to node 1 (west)");
        pushBeat(5'b01000, '0, 1'b0, 1'b1);
        applyStimulus(!MC, 5'd1, 20'h00005);
        waitIdle("u1");

`ifdef MCAST_EN
        $display("[TB] multicast fork, no backpressure");
        pushMcast();
        vcycles = 0;
        applyStimulus(1'b1, '0, MC_MAP);
        waitIdle("mc");
        checkOutput("mc_cycles", vcycles, 32'd5);

        $display("[TB] multicast fork, beat 2 stalled for 3 cycles");
        pushMcast();
        vcycles = 0;
        applyStimulus(1'b1, '0, MC_MAP);
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checkOutput("hold_port", {27'b0, out_port}, 32'b00001);
            checkOutput("hold_maddr", {12'b0, out_maddr}, 32'h00100);
            checkOutput("hold_last", {31'b0, out_last}, 32'd0);
            checkOutput("hold_in_ready", {31'b0, in_ready}, 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        waitIdle("stall");
        checkOutput("stall_cycles", vcycles, 32'd8);

        $display("[TB] empty multicast bitmap");
        applyStimulus(1'b1, '0, '0);
        checkOutput("bad_m_err", {31'b0, err_bad_addr}, 32'd1);
        checkOutput("bad_m_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("bad_m_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        checkOutput("bad_m_err_clr", {31'b0, err_bad_addr}, 32'd0);

        $display("[TB] reset during beat 3");
        pushMcast();
        applyStimulus(1'b1, '0, MC_MAP);
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("pre_rst_port", {27'b0, out_port}, 32'b00010);
        rst_ = 1'b0;
        sb.delete();
        #1;
        checkOutput("async_rst_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("async_rst_port", {27'b0, out_port}, 32'd0);
        @(posedge clk); #1;
        rst_ = 1'b1;
        @(posedge clk); #1;
        checkOutput("post_rst_ready", {31'b0, in_ready}, 32'd1);
`endif

        $display("[TB] unicast to own node 9");
        pushBeat(5'b10000, MC ? 20'h00200 : 20'h00000, 1'b1, 1'b1);
        applyStimulus(1'b0, 5'd9, '0);
        checkOutput("u9_absorb", {31'b0, out_absorb}, 32'd1);
        waitIdle("u9");

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
